mvm_rect_sat: RTL and testbench

- Next-generation matrix-vector multiplier: computes y = A·x for a rectangular signed M×N matrix A and N-vector x.
- Uses P parallel MAC lanes. Results are saturated to a configurable output width, and a sticky overflow flag reports clipping.
- Keeps the existing serial load protocol (startMatrix / startVector / start / done), adds an explicit output-valid strobe, and lets a stored matrix be reused across many vectors.

---
 rtl/mvm_rect_sat.sv | 131 +++++++++++++
 tb/tb_mvm_rect_sat.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_rect_sat.sv
// mvm_rect_sat: P-lane signed M x N matrix-vector multiplier with saturated output and sticky clip flag.
// Define MVM_RELU_EN to clamp negative results to zero after saturation.
module mvm_rect_sat #(
    parameter int M = 4,
    parameter int N = 3,
    parameter int P = 2,
    parameter int IN_WIDTH = 8,
    parameter int OUT_WIDTH = 2*IN_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        startMatrix,
    input  logic                        startVector,
    input  logic                        start,
    input  logic signed [IN_WIDTH-1:0]  data_in,
    output logic                        done,
    output logic                        out_valid,
    output logic signed [OUT_WIDTH-1:0] data_out,
    output logic                        busy,
    output logic                        sat
);
    localparam int ACC = 2*IN_WIDTH + $clog2(N);
    localparam int PW = 2*IN_WIDTH;
    localparam int W = ACC > OUT_WIDTH ? ACC : OUT_WIDTH;
    localparam int Q = M/P;
    localparam int AW = M*N > 1 ? $clog2(M*N) : 1;
    localparam int XW = N > 1 ? $clog2(N) : 1;
    localparam int YW = M > 1 ? $clog2(M) : 1;
    localparam int QW = Q > 1 ? $clog2(Q) : 1;
    localparam int OCW = $clog2(M+2);
    localparam logic signed [W-1:0] SMAX = {{(W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [W-1:0] SMIN = ~SMAX;

    if (M % P != 0) begin : g_bad_lanes
        $error("mvm_rect_sat: M must be a multiple of P");
    end

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_X, COMPUTE, OUTPUT} state_t;
    state_t state;

    logic signed [IN_WIDTH-1:0]  a [M*N];
    logic signed [IN_WIDTH-1:0]  x [N];
    logic signed [OUT_WIDTH-1:0] y [M];
    logic signed [ACC-1:0]       acc [P];
    logic signed [ACC-1:0]       nxt [P];
    logic signed [PW-1:0]        prod [P];
    logic signed [OUT_WIDTH-1:0] yv [P];
    logic [P-1:0]                clip;
    logic [AW-1:0]               cnt;
    logic [XW-1:0]               col;
    logic [QW-1:0]               pass;
    logic [OCW-1:0]              ocnt;

    assign busy = state != IDLE;

    always_comb begin
        clip = '0;
        for (int l = 0; l < P; l++) begin
            prod[l] = PW'(a[AW'((int'(pass)*P + l)*N + int'(col))]) * PW'(x[col]);
            nxt[l] = acc[l] + ACC'(prod[l]);
`ifdef MVM_RELU_EN
            clip[l] = W'(nxt[l]) > SMAX;
            yv[l] = clip[l] ? SMAX[OUT_WIDTH-1:0] : nxt[l][ACC-1] ? '0 : OUT_WIDTH'(nxt[l]);
`else
            clip[l] = W'(nxt[l]) > SMAX || W'(nxt[l]) < SMIN;
            yv[l] = W'(nxt[l]) > SMAX ? SMAX[OUT_WIDTH-1:0] : W'(nxt[l]) < SMIN ? SMIN[OUT_WIDTH-1:0] : OUT_WIDTH'(nxt[l]);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            a <= '{default: '0};
            x <= '{default: '0};
            y <= '{default: '0};
            acc <= '{default: '0};
            cnt <= '0;
            col <= '0;
            pass <= '0;
            ocnt <= '0;
            done <= 1'b0;
            out_valid <= 1'b0;
            sat <= 1'b0;
            data_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    col <= '0;
                    pass <= '0;
                    ocnt <= '0;
                    acc <= '{default: '0};
                    state <= startMatrix ? LOAD_A : startVector ? LOAD_X : start ? COMPUTE : IDLE;
                    if (!startMatrix && !startVector && start) sat <= 1'b0;
                end
                LOAD_A: begin
                    a[cnt] <= data_in;
                    cnt <= cnt + 1'b1;
                    if (cnt == AW'(M*N-1)) state <= IDLE;
                end
                LOAD_X: begin
                    x[XW'(cnt)] <= data_in;
                    cnt <= cnt + 1'b1;
                    if (cnt == AW'(N-1)) state <= IDLE;
                end
                COMPUTE: begin
                    col <= col + 1'b1;
                    acc <= nxt;
                    // last column of a pass: retire all lanes and start the next row group
                    if (col == XW'(N-1)) begin
                        col <= '0;
                        acc <= '{default: '0};
                        for (int l = 0; l < P; l++) y[YW'(int'(pass)*P + l)] <= yv[l];
                        sat <= sat | (|clip);
                        pass <= pass + 1'b1;
                        if (pass == QW'(Q-1)) state <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    ocnt <= ocnt + 1'b1;
                    done <= ocnt == '0;
                    out_valid <= ocnt != '0 && ocnt <= OCW'(M);
                    if (ocnt != '0 && ocnt <= OCW'(M)) data_out <= y[YW'(ocnt - 1'b1)];
                    if (ocnt == OCW'(M+1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mvm_rect_sat.sv
// tb_mvm_rect_sat: directed self-checking bench for mvm_rect_sat at M=4 N=3 P=2 IN=8 OUT=16.
module tb_mvm_rect_sat;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic startMatrix = 1'b0;
    logic startVector = 1'b0;
    logic start = 1'b0;
    logic signed [7:0] data_in = '0;
    logic done, out_valid, busy, sat;
    logic signed [15:0] data_out;
    int checks = 0;
    int errors = 0;

    mvm_rect_sat dut (
        .clk(clk), .reset(reset), .startMatrix(startMatrix), .startVector(startVector),
        .start(start), .data_in(data_in), .done(done), .out_valid(out_valid),
        .data_out(data_out), .busy(busy), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_matrix(input int m[12], input bit with_start, output int done_seen);
        startMatrix = 1'b1;
        start = with_start;
        tick();
        startMatrix = 1'b0;
        start = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            data_in = 8'(m[i]);
            tick();
            done_seen += int'(done);
        end
    endtask

    task automatic load_vector(input int v[3]);
        startVector = 1'b1;
        tick();
        startVector = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_in = 8'(v[i]);
            tick();
        end
    endtask

    // Runs one computation and records what the DUT produced; callers judge the results.
    task automatic run(input bit poke, output int lat, output logic signed [15:0] ys[4],
                       output logic [3:0] vm, output int extra_done, output logic endv,
                       output logic endb, output logic s);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        extra_done = 0;
        for (int j = 0; j < 4; j++) begin
            if (poke && j == 1) begin
                start = 1'b1;
                startVector = 1'b1;
                data_in = 8'sd55;
            end
            tick();
            start = 1'b0;
            startVector = 1'b0;
            ys[j] = data_out;
            vm[j] = out_valid;
            extra_done += int'(done);
        end
        tick();
        endv = out_valid;
        endb = busy;
        s = sat;
        extra_done += int'(done);
    endtask

    int lat, xd;
    logic signed [15:0] ys[4];
    logic [3:0] vm;
    logic endv, endb, s;

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        checks++;
        if ({busy, done, out_valid, sat} !== 4'b0000 || data_out !== 16'sd0) begin
            errors++;
            $display("FAIL reset flags busy/done/valid/sat=%b data_out=%0d, want 0000 and 0", {busy, done, out_valid, sat}, data_out);
        end
    endtask

    task automatic test_basic();
        int exp[4];
`ifdef MVM_RELU_EN
        exp = '{9, 21, 33, 0};
`else
        exp = '{9, 21, 33, -9};
`endif
        load_matrix('{1, 2, 3, 4, 5, 6, 7, 8, 9, -1, -2, -3}, 1'b0, xd);
        load_vector('{1, 1, 2});
        run(1'b0, lat, ys, vm, xd, endv, endb, s);
        checks++;
        if (lat !== 7) begin errors++; $display("FAIL basic latency got %0d want 7", lat); end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (ys[j] !== 16'(exp[j])) begin errors++; $display("FAIL basic y[%0d] got %0d want %0d", j, ys[j], exp[j]); end
        end
        checks++;
        if ({vm, endv, endb, s} !== 7'b1111000 || xd !== 0) begin
            errors++;
            $display("FAIL basic handshake valid=%b end_valid=%b end_busy=%b sat=%b extra_done=%0d, want 1111 0 0 0 0", vm, endv, endb, s, xd);
        end
    endtask

    task automatic test_matrix_reuse();
        int exp[4];
`ifdef MVM_RELU_EN
        exp = '{3, 6, 9, 0};
`else
        exp = '{3, 6, 9, -3};
`endif
        load_vector('{0, 0, 1});
        run(1'b0, lat, ys, vm, xd, endv, endb, s);
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (ys[j] !== 16'(exp[j])) begin errors++; $display("FAIL reuse y[%0d] got %0d want %0d", j, ys[j], exp[j]); end
        end
    endtask

    task automatic test_saturation();
        int m[12];
        logic signed [15:0] lo;
        logic lo_sat;
`ifdef MVM_RELU_EN
        lo = 16'sd0;
        lo_sat = 1'b0;
`else
        lo = -16'sd32768;
        lo_sat = 1'b1;
`endif
        for (int i = 0; i < 12; i++) m[i] = 127;
        load_matrix(m, 1'b0, xd);
        load_vector('{127, 127, 127});
        run(1'b0, lat, ys, vm, xd, endv, endb, s);
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (ys[j] !== 16'sd32767) begin errors++; $display("FAIL sat_hi y[%0d] got %0d want 32767", j, ys[j]); end
        end
        checks++;
        if (s !== 1'b1) begin errors++; $display("FAIL sat_hi flag got %b want 1", s); end
        load_vector('{-128, -128, -128});
        run(1'b0, lat, ys, vm, xd, endv, endb, s);
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (ys[j] !== lo) begin errors++; $display("FAIL sat_lo y[%0d] got %0d want %0d", j, ys[j], lo); end
        end
        checks++;
        if (s !== lo_sat) begin errors++; $display("FAIL sat_lo flag got %b want %b", s, lo_sat); end
        load_vector('{1, 1, 2});
        run(1'b0, lat, ys, vm, xd, endv, endb, s);
        checks++;
        if (ys[0] !== 16'sd508 || s !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear y0=%0d sat=%b want 508 and 0", ys[0], s);
        end
    endtask

    task automatic test_mid_reset();
        int dn;
        load_matrix('{1, 2, 3, 4, 5, 6, 7, 8, 9, -1, -2, -3}, 1'b0, xd);
        load_vector('{1, 1, 2});
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++;
        if (busy !== 1'b0 || data_out !== 16'sd0) begin
            errors++;
            $display("FAIL mid_reset busy=%b data_out=%0d want 0 and 0", busy, data_out);
        end
        dn = 0;
        repeat (12) begin
            tick();
            dn += int'(done) + int'(out_valid);
        end
        checks++;
        if (dn !== 0) begin errors++; $display("FAIL mid_reset stray done/valid cycles got %0d want 0", dn); end
        run(1'b0, lat, ys, vm, xd, endv, endb, s);
        checks++;
        if (lat !== 7 || ys[0] !== 16'sd0 || ys[1] !== 16'sd0 || ys[2] !== 16'sd0 || ys[3] !== 16'sd0) begin
            errors++;
            $display("FAIL mid_reset rerun lat=%0d y=%0d,%0d,%0d,%0d want 7 and 0,0,0,0", lat, ys[0], ys[1], ys[2], ys[3]);
        end
    endtask

    task automatic test_ignored_strobes();
        int dn;
        load_matrix('{1, 2, 3, 4, 5, 6, 7, 8, 9, -1, -2, -3}, 1'b0, xd);
        load_vector('{1, 1, 2});
        run(1'b1, lat, ys, vm, xd, endv, endb, s);
        dn = 0;
        repeat (12) begin
            tick();
            dn += int'(done) + int'(busy);
        end
        checks++;
        if (ys[0] !== 16'sd9 || ys[1] !== 16'sd21 || ys[2] !== 16'sd33 || vm !== 4'b1111 || xd !== 0 || dn !== 0) begin
            errors++;
            $display("FAIL ignore_output y=%0d,%0d,%0d valid=%b extra_done=%0d later=%0d want 9,21,33 1111 0 0", ys[0], ys[1], ys[2], vm, xd, dn);
        end
        load_matrix('{1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1}, 1'b1, xd);
        checks++;
        if (xd !== 0 || busy !== 1'b0) begin errors++; $display("FAIL ignore_idle done_during_load=%0d busy=%b want 0 0", xd, busy); end
        run(1'b0, lat, ys, vm, xd, endv, endb, s);
        checks++;
        if (ys[0] !== 16'sd1 || ys[1] !== 16'sd1 || ys[2] !== 16'sd2 || ys[3] !== 16'sd4) begin
            errors++;
            $display("FAIL ignore_idle y=%0d,%0d,%0d,%0d want 1,1,2,4", ys[0], ys[1], ys[2], ys[3]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_matrix_reuse();
        test_saturation();
        test_mid_reset();
        test_ignored_strobes();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
